// File: rtl/acc_sub_div.sv
// ---------------------------------------------------------------------------
// acc_sub_div
//   Repeated-subtraction divider. It is the reverse-direction companion to a
//   2^W modulo accumulator. A start request in IDLE loads the dividend A and
//   captures the divisor X. In RUN, each ce-qualified edge subtracts X from
//   the residue ACC and counts the step in Q. The first subtraction that
//   would borrow ends the run. At that point Q = A / X and R = A % X.
//   A zero divisor goes straight to DONE with err set and Q saturated.
//
// Ports
//   clk    : system clock, rising edge
//   rst    : asynchronous active-high reset
//   ce     : clock enable; state and outputs freeze while low
//   start  : division request, accepted only in IDLE with ce=1
//   A      : dividend, captured on accept
//   X      : divisor, captured on accept
//   ACC    : running residue (A - Q*X)
//   Q      : quotient / subtraction count
//   R      : remainder, meaningful while done=1
//   BO     : borrow-out, high for the ce-cycle after the terminating step
//   busy   : high in RUN
//   done   : high in DONE
//   err    : divide-by-zero flag, meaningful with done
// ---------------------------------------------------------------------------
module acc_sub_div #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         ce,
   input  logic         start,
   input  logic [W-1:0] A,
   input  logic [W-1:0] X,
   output logic [W-1:0] ACC,
   output logic [W-1:0] Q,
   output logic [W-1:0] R,
   output logic         BO,
   output logic         busy,
   output logic         done,
   output logic         err
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t       r_state;
   logic [W-1:0] r_xr;
   logic [W-1:0] r_acc;
   logic [W-1:0] r_q;
   logic [W-1:0] r_r;
   logic         r_bo;
   logic         r_err;

   // The subtraction is widened by one bit. The extra MSB is the borrow,
   // and a borrow means the residue is already smaller than the divisor.
   logic [W:0]   w_diff;
   logic         w_borrow;

   assign w_diff   = {1'b0, r_acc} - {1'b0, r_xr};
   assign w_borrow = w_diff[W];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_xr    <= '0;
         r_acc   <= '0;
         r_q     <= '0;
         r_r     <= '0;
         r_bo    <= 1'b0;
         r_err   <= 1'b0;
      end else if (ce) begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_acc <= A;
                  if (X == '0) begin
                     // Division by zero: report saturated quotient at once.
                     r_q     <= '1;
                     r_r     <= A;
                     r_err   <= 1'b1;
                     r_state <= S_DONE;
                  end else begin
                     r_xr    <= X;
                     r_q     <= '0;
                     r_err   <= 1'b0;
                     r_state <= S_RUN;
                  end
               end
            end
            S_RUN: begin
               if (w_borrow) begin
                  // The residue is left unwrapped. It becomes the remainder.
                  r_r     <= r_acc;
                  r_bo    <= 1'b1;
                  r_state <= S_DONE;
               end else begin
                  r_acc <= w_diff[W-1:0];
                  r_q   <= r_q + W'(1);
               end
            end
            S_DONE: begin
               r_bo    <= 1'b0;
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   // Status flags decode the state register only, so they never depend on start.
   assign busy = (r_state == S_RUN);
   assign done = (r_state == S_DONE);
   assign ACC  = r_acc;
   assign Q    = r_q;
   assign R    = r_r;
   assign BO   = r_bo;
   assign err  = r_err;

endmodule

// File: tb/tb_acc_sub_div.sv
// ---------------------------------------------------------------------------
// tb_acc_sub_div
//   Self-checking bench for acc_sub_div (W=4). A behavioural model tracks
//   the division by step count: after k steps the residue is A-k*X, and the
//   run ends after A/X steps with remainder A%X. A compare process checks
//   every DUT output against the model on each falling edge. Directed
//   scenarios pin the model with literal values. Randomised divisions, run
//   with a random clock enable, cover the rest.
// ---------------------------------------------------------------------------
module tb_acc_sub_div;

   logic       clk;
   logic       rst;
   logic       ce;
   logic       start;
   logic [3:0] a_in;
   logic [3:0] x_in;
   logic [3:0] acc_o;
   logic [3:0] q_o;
   logic [3:0] r_o;
   logic       bo_o;
   logic       busy_o;
   logic       done_o;
   logic       err_o;

   int n_checks = 0;
   int n_pass   = 0;

   acc_sub_div #(.W(4)) dut (
      .clk   (clk),
      .rst   (rst),
      .ce    (ce),
      .start (start),
      .A     (a_in),
      .X     (x_in),
      .ACC   (acc_o),
      .Q     (q_o),
      .R     (r_o),
      .BO    (bo_o),
      .busy  (busy_o),
      .done  (done_o),
      .err   (err_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
   endtask

   // ---------------- behavioural model ----------------
   // m_mode: 0 = idle, 1 = running, 2 = done.
   // m_k is the number of subtractions already performed.
   int m_mode, m_k, m_a, m_x;
   int m_acc, m_q, m_r, m_bo, m_err;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_mode <= 0; m_k <= 0; m_a <= 0; m_x <= 0;
         m_acc  <= 0; m_q <= 0; m_r <= 0; m_bo <= 0; m_err <= 0;
      end else if (ce) begin
         if (m_mode == 0) begin
            if (start) begin
               m_acc <= int'(a_in);
               if (x_in == 4'd0) begin
                  m_mode <= 2; m_q <= 15; m_r <= int'(a_in); m_err <= 1;
               end else begin
                  m_mode <= 1; m_k <= 0; m_a <= int'(a_in); m_x <= int'(x_in);
                  m_q <= 0; m_err <= 0;
               end
            end
         end else if (m_mode == 1) begin
            if (m_k == m_a / m_x) begin
               m_mode <= 2; m_r <= m_a % m_x; m_bo <= 1;
            end else begin
               m_k   <= m_k + 1;
               m_q   <= m_k + 1;
               m_acc <= m_a - (m_k + 1) * m_x;
            end
         end else begin
            m_mode <= 0; m_bo <= 0;
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      chk("acc",  int'(acc_o),  m_acc);
      chk("q",    int'(q_o),    m_q);
      chk("bo",   int'(bo_o),   m_bo);
      chk("busy", int'(busy_o), (m_mode == 1) ? 1 : 0);
      chk("done", int'(done_o), (m_mode == 2) ? 1 : 0);
      chk("err",  int'(err_o),  m_err);
      if (m_mode == 2) chk("r", int'(r_o), m_r);
   end

   // ---------------- stimulus helpers ----------------
   task automatic set_ce(input int mode);
      if (mode == 0)      ce = 1'b1;
      else if (mode == 1) ce = ~ce;
      else                ce = (($urandom % 4) != 0);
   endtask

   task automatic run_div(input int a, input int x, input int mode,
                          output int q_seen, output int r_seen, output int err_seen);
      int guard;
      guard    = 0;
      q_seen   = -1;
      r_seen   = -1;
      err_seen = -1;
      a_in  = 4'(a);
      x_in  = 4'(x);
      start = 1'b1;
      do begin
         set_ce(mode);
         @(negedge clk);
         guard++;
      end while (m_mode == 0 && guard < 100);
      start = 1'b0;
      while (m_mode != 0 && guard < 300) begin
         if (done_o === 1'b1) begin
            q_seen   = int'(q_o);
            r_seen   = int'(r_o);
            err_seen = int'(err_o);
         end
         // A start pulse during RUN must be ignored.
         start = (m_mode == 1) ? 1'($urandom % 2) : 1'b0;
         set_ce(mode);
         @(negedge clk);
         guard++;
      end
      start = 1'b0;
      if (guard >= 100 && q_seen < 0) chk("timeout", 0, 1);
      $display("div A=%0d X=%0d ce_mode=%0d -> Q=%0d R=%0d err=%0d", a, x, mode, q_seen, r_seen, err_seen);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int qs, rs, es, cnt, ra, rx;
      rst = 1'b0; ce = 1'b0; start = 1'b0; a_in = '0; x_in = '0;
      #1 rst = 1'b1;
      #1;
      chk("rst_acc",  int'(acc_o),  0);
      chk("rst_q",    int'(q_o),    0);
      chk("rst_r",    int'(r_o),    0);
      chk("rst_bo",   int'(bo_o),   0);
      chk("rst_busy", int'(busy_o), 0);
      chk("rst_done", int'(done_o), 0);
      chk("rst_err",  int'(err_o),  0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      // T1: 13 / 3
      ce = 1'b1; a_in = 4'd13; x_in = 4'd3; start = 1'b1;
      @(negedge clk); start = 1'b0;
      chk("t1_acc0", int'(acc_o), 13);
      chk("t1_busy", int'(busy_o), 1);
      for (int i = 1; i <= 4; i++) begin
         @(negedge clk);
         chk("t1_acc_step", int'(acc_o), 13 - 3 * i);
         chk("t1_q_step",   int'(q_o), i);
         chk("t1_bo_low",   int'(bo_o), 0);
      end
      @(negedge clk);
      chk("t1_done", int'(done_o), 1);
      chk("t1_bo",   int'(bo_o), 1);
      chk("t1_q",    int'(q_o), 4);
      chk("t1_r",    int'(r_o), 1);
      chk("t1_err",  int'(err_o), 0);
      chk("t1_acc",  int'(acc_o), 1);
      @(negedge clk);
      chk("t1_idle_done", int'(done_o), 0);
      chk("t1_idle_bo",   int'(bo_o), 0);
      $display("div A=13 X=3 directed -> Q=4 R=1 expected");

      // T2: 2 / 3
      a_in = 4'd2; x_in = 4'd3; start = 1'b1;
      @(negedge clk); start = 1'b0;
      chk("t2_acc0", int'(acc_o), 2);
      @(negedge clk);
      chk("t2_done", int'(done_o), 1);
      chk("t2_bo",   int'(bo_o), 1);
      chk("t2_q",    int'(q_o), 0);
      chk("t2_r",    int'(r_o), 2);
      @(negedge clk);
      $display("div A=2 X=3 directed -> Q=0 R=2 expected");

      // T3: 9 / 0
      a_in = 4'd9; x_in = 4'd0; start = 1'b1;
      @(negedge clk); start = 1'b0;
      chk("t3_done", int'(done_o), 1);
      chk("t3_err",  int'(err_o), 1);
      chk("t3_q",    int'(q_o), 15);
      chk("t3_r",    int'(r_o), 9);
      chk("t3_bo",   int'(bo_o), 0);
      chk("t3_busy", int'(busy_o), 0);
      @(negedge clk);
      chk("t3_idle", int'(done_o), 0);
      $display("div A=9 X=0 directed -> Q=15 R=9 err=1 expected");

      // T4: 15 / 1, also clears err left over from T3
      a_in = 4'd15; x_in = 4'd1; start = 1'b1;
      @(negedge clk); start = 1'b0;
      chk("t4_err_clr", int'(err_o), 0);
      chk("t4_q_clr",   int'(q_o), 0);
      cnt = 0;
      while (busy_o === 1'b1 && cnt < 40) begin
         cnt++;
         @(negedge clk);
      end
      chk("t4_busy_len", cnt, 16);
      chk("t4_q", int'(q_o), 15);
      chk("t4_r", int'(r_o), 0);
      @(negedge clk);
      $display("div A=15 X=1 directed -> Q=15 R=0 expected");

      // T5: 13 / 3 with alternating ce
      run_div(13, 3, 1, qs, rs, es);
      chk("t5_q", qs, 4);
      chk("t5_r", rs, 1);

      // T6: reset mid-run, with a start pulse during RUN
      ce = 1'b1; a_in = 4'd15; x_in = 4'd2; start = 1'b1;
      @(negedge clk); start = 1'b0;
      repeat (3) @(negedge clk);
      start = 1'b1;
      @(negedge clk); start = 1'b0;
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("t6_acc",  int'(acc_o), 0);
      chk("t6_q",    int'(q_o), 0);
      chk("t6_busy", int'(busy_o), 0);
      chk("t6_done", int'(done_o), 0);
      @(negedge clk);
      rst = 1'b0;
      $display("div A=15 X=2 aborted by reset");

      // Random divisions with random ce
      repeat (40) begin
         ra = int'($urandom_range(0, 15));
         rx = (($urandom % 8) == 0) ? 0 : int'($urandom_range(1, 15));
         run_div(ra, rx, 2, qs, rs, es);
         chk("rnd_q",   qs, (rx == 0) ? 15 : ra / rx);
         chk("rnd_r",   rs, (rx == 0) ? ra : ra % rx);
         chk("rnd_err", es, (rx == 0) ? 1 : 0);
      end

      @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
